imem_loader: RTL and testbench

Boot-time writer for the instruction memory. Receives a framed little-endian byte stream over a valid/ready byte interface and assembles it into 32-bit words. Issues word writes with byte strobes to the instruction memory's write port, and holds the core in reset until a frame has been loaded and its checksum verified. Sits between the host byte link (UART RX or debug bridge) and the instruction memory.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_word_packer.sv | 79 +++++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Holds the frame FSM state encoding, the length width and the strobe helper.
package imem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  // Lane strobe for a word whose highest filled lane is last_lane.
  function automatic logic [3:0] strb_from_lanes(input logic [1:0] last_lane);
    logic [3:0] strb;
    case (last_lane)
      2'd0:    strb = 4'b0001;
      2'd1:    strb = 4'b0011;
      2'd2:    strb = 4'b0111;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-link, memory write port and boot status bundle of the loader.
// The loader uses the slave view; the host/memory side uses the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              core_hold;
  logic              done;
  logic              err;

  modport slave (
    input  rx_data, rx_valid, start,
    output rx_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, core_hold, done, err
  );

  modport master (
    output rx_data, rx_valid, start,
    input  rx_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, core_hold, done, err
  );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian payload bytes into 32-bit words and issues one
// registered write per full word or per final partial word.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte,
  input  logic              i_last,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic [3:0]        o_wstrb
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       r_acc;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;

  logic [31:0]       w_acc_merged;
  logic              w_flush;

  // Accumulator with the incoming byte dropped into the current lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_acc_merged[8*gi +: 8] = (r_lane == 2'(gi)) ? i_byte : r_acc[8*gi +: 8];
  end

  assign w_flush = i_byte_vld && ((r_lane == 2'd3) || i_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_lane  <= '0;
      r_waddr <= BASE;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_clear) begin
        r_acc   <= '0;
        r_lane  <= '0;
        r_waddr <= BASE;
      end else if (i_byte_vld) begin
        if (w_flush) begin
          // Accumulator empties here so the next byte lands in lane 0.
          r_we    <= 1'b1;
          r_addr  <= r_waddr;
          r_wdata <= w_acc_merged;
          r_wstrb <= strb_from_lanes(r_lane);
          r_acc   <= '0;
          r_lane  <= '0;
          r_waddr <= r_waddr + ADDR_W'(4);
        end else begin
          r_acc  <= w_acc_merged;
          r_lane <= r_lane + 2'd1;
        end
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_wstrb = r_wstrb;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/payload/CSUM frames from a byte link, writes the
// payload to instruction memory and releases the core once the frame checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MEM_BYTES);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_sum;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;

  logic             w_rx_ready;
  logic             w_core_hold;
  logic             w_done;
  logic             w_err;
  logic             w_accept;
  logic             w_restart;
  logic             w_last;
  logic             w_payload;
  logic [LEN_W-1:0] w_len_full;
  logic [7:0]       w_sum_next;

  assign w_accept   = bus.rx_valid && w_rx_ready;
  assign w_len_full = {bus.rx_data, r_len_lo};
  assign w_sum_next = r_sum + bus.rx_data;
  assign w_last     = (r_cnt == (r_len - LEN_W'(1)));
  assign w_payload  = w_accept && (r_state == ST_DATA);
  assign w_restart  = bus.start && ((r_state == ST_DONE) || (r_state == ST_ERR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LEN_LO;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    w_core_hold  = 1'b1;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_LEN_LO: begin
        w_rx_ready = 1'b1;
        if (w_accept) w_state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        w_rx_ready = 1'b1;
        if (w_accept) begin
          if ({1'b0, w_len_full} > MAX_LEN) w_state_next = ST_ERR;
          else if (w_len_full == '0)        w_state_next = ST_CSUM;
          else                              w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_rx_ready = 1'b1;
        if (w_accept && w_last) w_state_next = ST_CSUM;
      end
      ST_CSUM: begin
        w_rx_ready = 1'b1;
        if (w_accept) w_state_next = (w_sum_next == 8'h00) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        w_core_hold = 1'b0;
        w_done      = 1'b1;
        if (bus.start) w_state_next = ST_LEN_LO;
      end
      ST_ERR: begin
        w_err = 1'b1;
        if (bus.start) w_state_next = ST_LEN_LO;
      end
      default: w_state_next = ST_LEN_LO;
    endcase
  end

  // Checksum covers every accepted byte, length and CSUM bytes included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= '0;
      r_len_lo <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else if (w_restart) begin
      r_sum    <= '0;
      r_len_lo <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_sum <= w_sum_next;
      case (r_state)
        ST_LEN_LO: r_len_lo <= bus.rx_data;
        ST_LEN_HI: begin
          r_len <= w_len_full;
          r_cnt <= '0;
        end
        ST_DATA:   r_cnt <= r_cnt + LEN_W'(1);
        default:   ;
      endcase
    end
  end

  imem_word_packer #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_restart),
    .i_byte_vld (w_payload),
    .i_byte     (bus.rx_data),
    .i_last     (w_last),
    .o_we       (bus.mem_we),
    .o_addr     (bus.mem_addr),
    .o_wdata    (bus.mem_wdata),
    .o_wstrb    (bus.mem_wstrb)
  );

  assign bus.rx_ready  = w_rx_ready;
  assign bus.core_hold = w_core_hold;
  assign bus.done      = w_done;
  assign bus.err       = w_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte and every
// memory write is captured and compared with hand-computed words.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(
    .MEM_BYTES (256),
    .BASE_ADDR (0),
    .ADDR_W    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [67:0] wr_q[$];
  logic [67:0] exp_q[$];
  logic [7:0]  fq[$];

  // Capture each write as {addr, wdata, wstrb} on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1)
      wr_q.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rx_ready_timeout", {67'd0, bus.rx_ready}, 68'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_fq(input bit gaps);
    foreach (fq[i]) send_byte(fq[i], gaps ? int'($urandom_range(0, 3)) : 0);
    fq.delete();
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_wr_count"}, 68'(wr_q.size()), 68'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag, input logic done_e, input logic err_e,
                              input logic hold_e, input logic rdy_e);
    chk({tag, "_done"},      {67'd0, bus.done},      {67'd0, done_e});
    chk({tag, "_err"},       {67'd0, bus.err},       {67'd0, err_e});
    chk({tag, "_core_hold"}, {67'd0, bus.core_hold}, {67'd0, hold_e});
    chk({tag, "_rx_ready"},  {67'd0, bus.rx_ready},  {67'd0, rdy_e});
  endtask

  task automatic check_reset_vals(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_mem_we"},    {67'd0, bus.mem_we}, 68'd0);
    chk({tag, "_mem_addr"},  68'(bus.mem_addr),   68'd0);
    chk({tag, "_mem_wdata"}, 68'(bus.mem_wdata),  68'd0);
    chk({tag, "_mem_wstrb"}, 68'(bus.mem_wstrb),  68'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_frame1(input logic [7:0] csum);
    fq = '{8'h08, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, csum};
  endtask

  task automatic expect_frame1();
    exp_q.push_back({32'h0000_0000, 32'h0000_0013, 4'b1111});
    exp_q.push_back({32'h0000_0004, 32'h0010_0093, 4'b1111});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Two full words; sum of 08+13+93+10 = 0xBE, so CSUM 0x42 closes to zero.
    load_frame1(8'h42);
    send_fq(1'b0);
    check_status("f1", 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame1();
    check_writes("f1");

    // N=5: partial final word, checked one cycle after the last payload byte.
    pulse_start();
    fq = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_fq(1'b0);
    chk("n5_last_we",    {67'd0, bus.mem_we}, 68'd1);
    chk("n5_last_addr",  68'(bus.mem_addr),   68'h4);
    chk("n5_last_wdata", 68'(bus.mem_wdata),  68'h0000_0005);
    chk("n5_last_wstrb", 68'(bus.mem_wstrb),  68'b0001);
    send_byte(8'hEC, 0);
    check_status("n5", 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'h0403_0201, 4'b1111});
    exp_q.push_back({32'h0000_0004, 32'h0000_0005, 4'b0001});
    check_writes("n5");

    // Same frame with a bad checksum: writes still happen, err raised.
    pulse_start();
    fq = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hED};
    send_fq(1'b0);
    check_status("n5_bad", 1'b0, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({32'h0000_0000, 32'h0403_0201, 4'b1111});
    exp_q.push_back({32'h0000_0004, 32'h0000_0005, 4'b0001});
    check_writes("n5_bad");

    // Recover with a good frame; a start pulse mid-frame must be ignored.
    pulse_start();
    fq = '{8'h08, 8'h00, 8'h13, 8'h00, 8'h00};
    send_fq(1'b0);
    pulse_start();
    fq = '{8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h42};
    send_fq(1'b0);
    check_status("recover", 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame1();
    check_writes("recover");

    // Off-by-one checksum on the two-word frame.
    pulse_start();
    load_frame1(8'h43);
    send_fq(1'b0);
    check_status("f1_bad", 1'b0, 1'b1, 1'b1, 1'b0);
    expect_frame1();
    check_writes("f1_bad");

    // Oversize length 0x0101 rejected right after LEN_HI.
    pulse_start();
    fq = '{8'h01, 8'h01};
    send_fq(1'b0);
    check_status("len_257", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_writes("len_257");

    // Empty frame.
    pulse_start();
    fq = '{8'h00, 8'h00, 8'h00};
    send_fq(1'b0);
    check_status("empty", 1'b0 ^ 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("empty");

    // Reset after six payload bytes: only the first word may be written.
    pulse_start();
    fq = '{8'h08, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    send_fq(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({32'h0000_0000, 32'h0000_0013, 4'b1111});
    check_writes("midrst");
    fq = '{8'h00, 8'h00, 8'h00};
    send_fq(1'b0);
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes("post_rst");

    // Random valid gaps must give the same write sequence.
    pulse_start();
    load_frame1(8'h42);
    send_fq(1'b1);
    check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame1();
    check_writes("gaps");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
